mul_issue_ctrl: RTL and testbench

Issue and collect controller for the two-stage Booth/Wallace 32×32 multiplier. It accepts multiply ops from the EXE stage over a valid/ready handshake and holds the operands stable across both multiplier cycles. It then selects the low or high word of the 64-bit product and presents it to the MEM stage over a second valid/ready handshake. At most one multiply is in flight.

---
 rtl/mul_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/collect controller for the two-stage 32x32 multiplier.
// Optional result forwarding from S2 via `define MUL_FORWARD_EN.
module mul_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             mul_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             m_resetn,
  output logic             m_signed,
  output logic [31:0]      m_x,
  output logic [31:0]      m_y,
  input  logic [63:0]      m_result
);

  typedef enum logic [1:0] {
    IDLE,
    S1,
    S2,
    OUT
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        x_q, x_d;
  logic [31:0]        y_q, y_d;
  logic [31:0]        res_q, res_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [1:0]         op_q, op_d;
  logic               sgn_q, sgn_d;
  logic               accept;
  logic               sel_hi;
  logic [31:0]        live_word;

  // op 11 falls through to the low word, same as op 00
  assign sel_hi    = (op_q == 2'b01) | (op_q == 2'b10);
  assign live_word = sel_hi ? m_result[63:32]
                            : m_result[31:0];

  assign m_x      = x_q;
  assign m_y      = y_q;
  assign m_signed = sgn_q;
  assign m_resetn = ~reset;
  assign out_tag  = tag_q;
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_result = res_q;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      S1: begin
      end
      S2: begin
`ifdef MUL_FORWARD_EN
        out_valid  = ~flush;
        out_result = live_word;
        in_ready   = out_ready & ~flush;
`endif
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~flush;
      end
      default: begin
      end
    endcase
    if (reset) in_ready = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tag_d   = tag_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    res_d   = res_q;

    if (accept) begin
      x_d   = in_x;
      y_d   = in_y;
      tag_d = in_tag;
      op_d  = in_op;
      sgn_d = (in_op != 2'b10);
    end

    if ((state_q == S2) && !flush) begin
      res_d = live_word;
    end

    unique case (state_q)
      IDLE: if (accept) state_d = S1;
      S1:   state_d = S2;
      S2: begin
`ifdef MUL_FORWARD_EN
        if (out_ready) begin
          state_d = accept ? S1 : IDLE;
        end else begin
          state_d = OUT;
        end
`else
        state_d = OUT;
`endif
      end
      OUT: begin
        if (out_ready) begin
          state_d = accept ? S1 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // operands are kept; only the sequence is abandoned
    if (flush && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge mul_clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      op_q    <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl.
// Multiplier modelled as an ideal combinational product.
module tb_mul_issue_ctrl;

`ifdef MUL_FORWARD_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_x, in_y;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;
  logic        m_resetn;
  logic        m_signed;
  logic [31:0] m_x, m_y;
  logic [63:0] m_result;
  logic [63:0] ex, ey;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    ex = m_signed ? {{32{m_x[31]}}, m_x} : {32'd0, m_x};
    ey = m_signed ? {{32{m_y[31]}}, m_y} : {32'd0, m_y};
    m_result = ex * ey;
  end

  mul_issue_ctrl #(.TAG_W(5)) dut (
    .mul_clk   (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .busy      (busy),
    .m_resetn  (m_resetn),
    .m_signed  (m_signed),
    .m_x       (m_x),
    .m_y       (m_y),
    .m_result  (m_result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  task automatic wait_res(input string name,
                          input logic [31:0] x,
                          input logic [31:0] exp,
                          input logic [4:0]  tag);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      chk({name, "_mx"}, m_x, x);
      tick();
      cyc++;
    end
    chk({name, "_mx_end"}, m_x, x);
    chk({name, "_lat"}, cyc, LAT);
    chk({name, "_vld"}, out_valid, 1);
    chk({name, "_res"}, out_result, exp);
    chk({name, "_tag"}, out_tag, tag);
  endtask

  task automatic run_op(input string name,
                        input logic [1:0]  op,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [4:0]  tag,
                        input logic [31:0] exp);
    in_op    = op;
    in_x     = x;
    in_y     = y;
    in_tag   = tag;
    in_valid = 1'b1;
    chk({name, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_res(name, x, exp, tag);
    tick();
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_x      = '0;
    in_y      = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_res", out_result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_mx", m_x, 0);
    chk("rst_sgn", m_signed, 0);
    chk("rst_inrdy", in_ready, 0);
    chk("rst_mrstn", m_resetn, 0);
    reset = 1'b0;
    #1;
    chk("rel_mrstn", m_resetn, 1);

    run_op("mulw_m1", 2'b00, 32'hFFFFFFFF,
           32'hFFFFFFFF, 5'd3, 32'h00000001);
    run_op("mulh_m1", 2'b01, 32'hFFFFFFFF,
           32'hFFFFFFFF, 5'd4, 32'h00000000);
    run_op("mulhu_m1", 2'b10, 32'hFFFFFFFF,
           32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE);
    run_op("mulh_min", 2'b01, 32'h80000000,
           32'h80000000, 5'd6, 32'h40000000);
    run_op("op11", 2'b11, 32'hFFFFFFFF,
           32'h00000002, 5'd7, 32'hFFFFFFFE);

    // backpressure
    out_ready = 1'b0;
    in_op     = 2'b10;
    in_x      = 32'h12345678;
    in_y      = 32'h9ABCDEF0;
    in_tag    = 5'd9;
    in_valid  = 1'b1;
    chk("bp_sgn_pre", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_sgn", m_signed, 0);
    wait_res("bp", 32'h12345678,
             32'h0B00EA4E, 5'd9);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_res", out_result, 32'h0B00EA4E);
      chk("bp_hold_tag", out_tag, 9);
      chk("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle", busy, 0);
    chk("bp_vld_off", out_valid, 0);

    // back-to-back with in_valid held
    in_op    = 2'b00;
    in_x     = 32'd7;
    in_y     = 32'd6;
    in_tag   = 5'd1;
    in_valid = 1'b1;
    tick();
    in_x   = 32'hFFFFFFFE;
    in_y   = 32'd3;
    in_tag = 5'd2;
    wait_res("b2b_a", 32'd7, 32'h0000002A, 5'd1);
    chk("b2b_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_res("b2b_b", 32'hFFFFFFFE,
             32'hFFFFFFFA, 5'd2);
    tick();
    chk("b2b_idle", busy, 0);

    // flush in S2
    in_op    = 2'b00;
    in_x     = 32'd5;
    in_y     = 32'd5;
    in_tag   = 5'd11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fl_s1_vld", out_valid, 0);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_s2_vld", out_valid, 0);
    chk("fl_s2_rdy", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_vld", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_quiet", out_valid, 0);
    end
    run_op("fl_next", 2'b00, 32'd2, 32'd3,
           5'd12, 32'h00000006);

    // reset in S1
    in_op    = 2'b01;
    in_x     = 32'h00001234;
    in_y     = 32'h00005678;
    in_tag   = 5'd13;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rs_s1", busy, 1);
    reset = 1'b1;
    #1;
    chk("rs_inrdy", in_ready, 0);
    chk("rs_mrstn", m_resetn, 0);
    tick();
    chk("rs_busy", busy, 0);
    chk("rs_vld", out_valid, 0);
    chk("rs_res", out_result, 0);
    chk("rs_tag", out_tag, 0);
    chk("rs_mx", m_x, 0);
    chk("rs_my", m_y, 0);
    chk("rs_sgn", m_signed, 0);
    chk("rs_inrdy2", in_ready, 0);
    reset = 1'b0;
    #1;
    run_op("rs_lo", 2'b00, 32'h00010000,
           32'h00010000, 5'd14, 32'h00000000);
    run_op("rs_hu", 2'b10, 32'h00010000,
           32'h00010000, 5'd15, 32'h00000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
